btle_bit_upsample: RTL
======================

// Module: btle_bit_upsample
// PURPOSE
//   Stage directly upstream of the Gaussian pulse-shaping filter in the BTLE TX chain. Accepts packet
//   bits over a valid/ready handshake and repeats each bit SAMPLE_PER_SYMBOL times, paced by sample_strobe.
//   Appends a flush tail so the filter's delay line drains, then marks the final sample with valid_last.
// PARAMETERS
//   SAMPLE_PER_SYMBOL  8   output samples per input bit (>=2)
//   FLUSH_LEN          16  tail samples after last bit (filter taps-1; 0 = no tail)
//   CNT_W              5   width of sample/flush counters; must hold max(SAMPLE_PER_SYMBOL,FLUSH_LEN)
// PORTS
//   clk                      in   1  clock
//   rst                      in   1  asynchronous, active-high reset
//   sample_strobe            in   1  one-cycle pulse per output sample slot
//   info_bit                 in   1  packet bit (1 -> +tap, 0 -> -tap downstream)
//   info_bit_valid           in   1  info_bit/info_bit_last valid
//   info_bit_last            in   1  qualifies final bit of packet
//   info_bit_ready           out  1  block can accept a bit this cycle
//   bit_upsample             out  1  repeated bit to filter
//   bit_upsample_valid       out  1  one-cycle pulse per output sample
//   bit_upsample_valid_last  out  1  coincident with valid on the final sample of packet
//   busy                     out  1  high from first accepted bit until cycle after valid_last
//   underrun                 out  1  sticky: bit slot missed while in RUN; cleared on next packet start
// BEHAVIOUR
//   - Reset: all outputs 0; FSM IDLE; counters 0; holding register empty.
//   - Transfer: bit accepted when info_bit_valid & info_bit_ready on a clk edge.
//   - One-entry holding register (hold_bit, hold_last, hold_full); info_bit_ready = ~hold_full (registered).
//     Accept and consume in the same cycle are legal; hold_full stays 1.
//   - FSM IDLE: hold_full -> RUN, load cur_bit/cur_last from hold, sample_cnt=0, clear underrun.
//   - RUN: on each sample_strobe emit cur_bit; registered output, valid exactly 1 cycle after strobe.
//     sample_cnt increments per strobe; at SAMPLE_PER_SYMBOL-1 symbol ends:
//       cur_last=1 -> FLUSH (FLUSH_LEN>0) or, if FLUSH_LEN==0, this sample gets valid_last, -> IDLE;
//       else hold_full -> load next bit, sample_cnt=0, same cycle (no gap);
//       else -> STALL, set underrun.
//   - STALL: no output; when hold_full, load bit -> RUN, count resumes at 0 on next strobe.
//   - FLUSH: on each strobe emit last packet bit value again (avoids spectral step); flush_cnt counts
//     0..FLUSH_LEN-1; sample at FLUSH_LEN-1 carries valid_last; -> IDLE.
//   - Strobe with nothing to emit (IDLE/STALL) is ignored. No output without strobe.
//   - Input bits arriving during FLUSH are held (ready drops when full) and start the next packet
//     from IDLE; packets never merge.
//   - Strobes back-to-back every cycle are supported (full-rate).
//   - busy = state != IDLE, registered; deasserts the cycle after valid_last.
//   - Reset mid-packet: immediate return to reset values; partial packet discarded, no valid_last.
// CONFIGURATION
//   BTLE_UPSAMPLE_LEADIN_EN defined: on leaving IDLE, state LEADIN first emits FLUSH_LEN samples of
//     the first bit's value (primes filter delay line) before the normal SAMPLE_PER_SYMBOL samples;
//     hold register still accepts next bit during LEADIN. FLUSH_LEN==0 skips LEADIN.
//   Not defined: no LEADIN state; first bit's first sample follows first post-load strobe.
// TESTING
//   1. SPS=8, FLUSH=16, strobe every cycle, bits 1,0,1 (last on 3rd) -> 24 data samples 8x1,8x0,8x1
//      then 16x1; valid_last only on sample 40; no gaps; underrun=0.
//   2. Strobe every 4th cycle, 2 bits -> valid pulses 1 cycle after each strobe, 32 total, count exact.
//   3. Starve input after bit 1 for 20 strobes -> underrun=1, no valid during stall, resume at
//      sample_cnt 0 when bit 2 arrives; underrun clears on next packet start.
//   4. FLUSH_LEN=0, single bit 0 with last -> 8 samples of 0, valid_last on 8th, busy drops next cycle.
//   5. rst pulsed mid-RUN after 5 samples -> all outputs 0 next edge; new packet processes cleanly.
//   6. BTLE_UPSAMPLE_LEADIN_EN, bits 0,1 -> 16x0 lead-in, 8x0, 8x1, 16x1 flush; valid_last on sample 48.

Source files
------------

// File: rtl/btle_bit_upsample.sv
// btle_bit_upsample
//   Sits in front of the Gaussian pulse-shaping filter in the BTLE TX chain.
//   It takes packet bits over a valid/ready handshake and repeats each bit
//   SAMPLE_PER_SYMBOL times, one sample per sample_strobe. After the last bit
//   it emits a flush tail of FLUSH_LEN copies of that bit so the filter delay
//   line drains, and it flags the final sample with bit_upsample_valid_last.
//
//   Build option: define BTLE_UPSAMPLE_LEADIN_EN to add a lead-in of FLUSH_LEN
//   samples of the first bit's value before the first symbol. This primes the
//   filter delay line. FLUSH_LEN == 0 skips the lead-in.
//
// Ports
//   clk                      in  clock
//   rst                      in  asynchronous, active-high reset
//   sample_strobe            in  one-cycle pulse per output sample slot
//   info_bit                 in  packet bit
//   info_bit_valid           in  info_bit / info_bit_last valid
//   info_bit_last            in  marks the final bit of a packet
//   info_bit_ready           out a bit can be accepted this cycle
//   bit_upsample             out repeated bit to the filter
//   bit_upsample_valid       out one-cycle pulse per output sample
//   bit_upsample_valid_last  out final sample of the packet
//   busy                     out packet in progress
//   underrun                 out sticky: a bit slot was missed mid-packet
module btle_bit_upsample #(
   parameter int unsigned SAMPLE_PER_SYMBOL = 8,
   parameter int unsigned FLUSH_LEN         = 16,
   parameter int unsigned CNT_W             = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_strobe,
   input  logic info_bit,
   input  logic info_bit_valid,
   input  logic info_bit_last,
   output logic info_bit_ready,
   output logic bit_upsample,
   output logic bit_upsample_valid,
   output logic bit_upsample_valid_last,
   output logic busy,
   output logic underrun
);

   localparam logic [CNT_W-1:0] SPS_LAST   = CNT_W'(SAMPLE_PER_SYMBOL - 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);
   localparam bit               HAS_FLUSH  = (FLUSH_LEN != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_STALL,
      S_FLUSH
`ifdef BTLE_UPSAMPLE_LEADIN_EN
      , S_LEADIN
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic               cur_bit_q, cur_bit_d;
   logic               cur_last_q, cur_last_d;
   logic               hold_bit_q, hold_bit_d;
   logic               hold_last_q, hold_last_d;
   logic               hold_full_q, hold_full_d;
   logic               ready_q;
   logic               out_bit_q, out_bit_d;
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;
   logic               busy_q, busy_d;
   logic               underrun_q, underrun_d;
   logic               accept;
   logic               consume;

   assign accept = info_bit_valid & ready_q;

   always_comb begin
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      cur_bit_d    = cur_bit_q;
      cur_last_d   = cur_last_q;
      underrun_d   = underrun_q;
      out_bit_d    = out_bit_q;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      consume      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (hold_full_q) begin
               consume      = 1'b1;
               cur_bit_d    = hold_bit_q;
               cur_last_d   = hold_last_q;
               sample_cnt_d = '0;
               flush_cnt_d  = '0;
               underrun_d   = 1'b0;
`ifdef BTLE_UPSAMPLE_LEADIN_EN
               state_d      = HAS_FLUSH ? S_LEADIN : S_RUN;
`else
               state_d      = S_RUN;
`endif
            end
         end

`ifdef BTLE_UPSAMPLE_LEADIN_EN
         S_LEADIN: begin
            if (sample_strobe) begin
               out_bit_d   = cur_bit_q;
               out_valid_d = 1'b1;
               if (flush_cnt_q == FLUSH_LAST) begin
                  sample_cnt_d = '0;
                  state_d      = S_RUN;
               end else begin
                  flush_cnt_d = flush_cnt_q + CNT_W'(1);
               end
            end
         end
`endif

         S_RUN: begin
            if (sample_strobe) begin
               out_bit_d   = cur_bit_q;
               out_valid_d = 1'b1;
               if (sample_cnt_q == SPS_LAST) begin
                  if (cur_last_q) begin
                     if (HAS_FLUSH) begin
                        flush_cnt_d = '0;
                        state_d     = S_FLUSH;
                     end else begin
                        out_last_d = 1'b1;
                        state_d    = S_IDLE;
                     end
                  end else if (hold_full_q) begin
                     // Reload in the symbol's last slot so the next bit
                     // follows with no gap.
                     consume      = 1'b1;
                     cur_bit_d    = hold_bit_q;
                     cur_last_d   = hold_last_q;
                     sample_cnt_d = '0;
                  end else begin
                     underrun_d = 1'b1;
                     state_d    = S_STALL;
                  end
               end else begin
                  sample_cnt_d = sample_cnt_q + CNT_W'(1);
               end
            end
         end

         S_STALL: begin
            if (hold_full_q) begin
               consume      = 1'b1;
               cur_bit_d    = hold_bit_q;
               cur_last_d   = hold_last_q;
               sample_cnt_d = '0;
               state_d      = S_RUN;
            end
         end

         S_FLUSH: begin
            if (sample_strobe) begin
               // The tail repeats the last bit to avoid a spectral step.
               out_bit_d   = cur_bit_q;
               out_valid_d = 1'b1;
               if (flush_cnt_q == FLUSH_LAST) begin
                  out_last_d = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  flush_cnt_d = flush_cnt_q + CNT_W'(1);
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      hold_bit_d  = hold_bit_q;
      hold_last_d = hold_last_q;
      hold_full_d = (hold_full_q & ~consume) | accept;
      if (accept) begin
         hold_bit_d  = info_bit;
         hold_last_d = info_bit_last;
      end
      // A held bit counts as packet activity even before the FSM loads it.
      busy_d = accept | hold_full_q | (state_q != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         sample_cnt_q <= '0;
         flush_cnt_q  <= '0;
         cur_bit_q    <= 1'b0;
         cur_last_q   <= 1'b0;
         hold_bit_q   <= 1'b0;
         hold_last_q  <= 1'b0;
         hold_full_q  <= 1'b0;
         ready_q      <= 1'b0;
         out_bit_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         cur_bit_q    <= cur_bit_d;
         cur_last_q   <= cur_last_d;
         hold_bit_q   <= hold_bit_d;
         hold_last_q  <= hold_last_d;
         hold_full_q  <= hold_full_d;
         ready_q      <= ~hold_full_d;
         out_bit_q    <= out_bit_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         busy_q       <= busy_d;
         underrun_q   <= underrun_d;
      end
   end

   assign info_bit_ready          = ready_q;
   assign bit_upsample            = out_bit_q;
   assign bit_upsample_valid      = out_valid_q;
   assign bit_upsample_valid_last = out_last_q;
   assign busy                    = busy_q;
   assign underrun                = underrun_q;

endmodule
